// File: rtl/led_pattern_if.sv
// Requester-side bundle for the LED pattern arbiter.
// Masters drive req/req_pattern; the arbiter reports ack, grant, busy and done.
interface led_pattern_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_pattern;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 done;

    modport master (
        output req, req_pattern,
        input  req_ack, grant, busy, done
    );

    modport slave (
        input  req, req_pattern,
        output req_ack, grant, busy, done
    );
endinterface

// File: rtl/led_pattern_arbiter.sv
// Round-robin owner of the board LED: plays one captured 8-step pattern
// per grant, paced by a step prescaler and gated by a debounced button.
module led_pattern_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int CNT_W           = 24,
    parameter int STEP_CYCLES     = 4000000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         button,
    led_pattern_if.slave bus,
    output logic         led
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   last_grant, sel, cand;
    logic [NUM_REQ-1:0] sel_oh;
    logic               found;
    logic [7:0]         pattern;
    logic [2:0]         step;
    logic [CNT_W-1:0]   presc, db_cnt;
    logic               sync1, btn_sync, btn_db;
    logic               led_raw, step_end, play_end;
    int                 j;

    assign step_end = (presc == CNT_W'(STEP_CYCLES - 1));
    assign play_end = (state == PLAY) && step_end && (step == 3'd7);

    // Search starts one past the last owner and wraps.
    always_comb begin
        found  = 1'b0;
        sel    = last_grant;
        sel_oh = '0;
        j      = 0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(last_grant) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            cand = IDX_W'(j);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        sel_oh[sel] = found;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (found)    state_nxt = PLAY;
            PLAY: if (play_end) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == PLAY);
        led_raw  = (state == PLAY) ? pattern[step] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.grant   <= '0;
            bus.req_ack <= '0;
            bus.done    <= 1'b0;
            pattern     <= '0;
            step        <= '0;
            presc       <= '0;
            last_grant  <= IDX_W'(NUM_REQ - 1);
        end else begin
            bus.req_ack <= '0;
            bus.done    <= 1'b0;
            if (state == IDLE) begin
                if (found) begin
                    pattern     <= bus.req_pattern[{sel, 3'b000} +: 8];
                    bus.grant   <= sel_oh;
                    bus.req_ack <= sel_oh;
                    last_grant  <= sel;
                    step        <= '0;
                    presc       <= '0;
                end
            end else if (step_end) begin
                presc <= '0;
                if (step == 3'd7) begin
                    bus.grant <= '0;
                    bus.done  <= 1'b1;
                end else begin
                    step <= step + 3'd1;
                end
            end else begin
                presc <= presc + CNT_W'(1);
            end
        end
    end

    // Button must differ from the accepted level for a full window to flip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            btn_sync <= 1'b0;
            btn_db   <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1    <= button;
            btn_sync <= sync1;
            if (btn_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign led = led_raw & btn_db;
endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Bench for led_pattern_arbiter: table of single plays plus hand-built
// sequences for button debounce, reset mid-play and back-to-back grants.
module tb_led_pattern_arbiter;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst;
    logic button;
    logic led;

    led_pattern_if #(.NUM_REQ(NR)) bus();

    led_pattern_arbiter #(
        .NUM_REQ(NR),
        .CNT_W(24),
        .STEP_CYCLES(4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .button(button),
        .bus(bus),
        .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] pats;
        logic [2:0]  g;
        logic [7:0]  led;
    } vec_t;

    typedef struct packed {
        logic [2:0] g;
        logic [7:0] pat;
    } exp_t;

    vec_t tv[8];
    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.req_ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ack_seen", {31'd0, ok}, 32'd1);
    endtask

    // Entered on the first play cycle (ack visible); ends in the IDLE cycle after done.
    task automatic check_play(input exp_t e);
        bit gok = 1'b1;
        chk("req_ack", bus.req_ack, e.g);
        chk("grant_start", bus.grant, e.g);
        bus.req = '0;
        bus.req_pattern = ~bus.req_pattern;
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) chk("ack_fall", bus.req_ack, 0);
            chk("led_step", led, e.pat[c / 4]);
            if (bus.grant !== e.g || bus.busy !== 1'b1 || bus.done !== 1'b0)
                gok = 1'b0;
        end
        chk("grant_held", {31'd0, gok}, 32'd1);
        @(negedge clk);
        chk("done_pulse", bus.done, 1);
        chk("grant_end", bus.grant, 0);
        chk("busy_end", bus.busy, 0);
        @(negedge clk);
        chk("done_fall", bus.done, 0);
        chk("no_regrant", bus.grant, 0);
    endtask

    initial begin
        bit   ok;
        bit   flag;
        exp_t e;
        int   cnt;
        int   gap;
        logic [2:0] gexp[4];

        tv[0] = '{3'b001, 24'h00_00_A5, 3'b001, 8'hA5};
        tv[1] = '{3'b111, 24'h3C_81_0F, 3'b010, 8'h81};
        tv[2] = '{3'b111, 24'h3C_81_0F, 3'b100, 8'h3C};
        tv[3] = '{3'b111, 24'h3C_81_0F, 3'b001, 8'h0F};
        tv[4] = '{3'b101, 24'h5A_00_11, 3'b100, 8'h5A};
        tv[5] = '{3'b011, 24'h00_C3_E7, 3'b001, 8'hE7};
        tv[6] = '{3'b100, 24'h96_00_00, 3'b100, 8'h96};
        tv[7] = '{3'b010, 24'h00_42_00, 3'b010, 8'h42};

        rst = 1'b1;
        button = 1'b1;
        bus.req = '0;
        bus.req_pattern = '0;
        repeat (2) @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ack", bus.req_ack, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("idle_led", led, 0);
        chk("idle_grant", bus.grant, 0);

        for (int i = 0; i < 8; i++) begin
            bus.req = tv[i].req;
            bus.req_pattern = tv[i].pats;
            sbq.push_back('{g: tv[i].g, pat: tv[i].led});
            wait_ack(ok);
            e = sbq.pop_front();
            if (ok) check_play(e);
        end

        // Button gating during a play of all-ones.
        button = 1'b0;
        repeat (6) @(negedge clk);
        bus.req = 3'b001;
        bus.req_pattern = 24'h00_00_FF;
        sbq.push_back('{g: 3'b001, pat: 8'hFF});
        wait_ack(ok);
        e = sbq.pop_front();
        if (ok) begin
            chk("btn_grant", bus.grant, e.g);
            bus.req = '0;
            chk("led_btn_off", led, 0);
            button = 1'b1;
            repeat (2) @(negedge clk);
            button = 1'b0;
            flag = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (led !== 1'b0) flag = 1'b0;
            end
            chk("led_short_pulse", {31'd0, flag}, 32'd1);
            button = 1'b1;
            flag = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (led !== 1'b0) flag = 1'b0;
            end
            chk("led_pre_debounce", {31'd0, flag}, 32'd1);
            @(negedge clk);
            chk("led_debounced", led, 1);
            chk("btn_grant_hold", bus.grant, e.g);
            flag = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.done === 1'b1) begin
                    flag = 1'b1;
                    break;
                end
            end
            chk("btn_done", {31'd0, flag}, 32'd1);
            chk("btn_grant_end", bus.grant, 0);
            @(negedge clk);
        end

        // Reset in step 3 of requester 1's play.
        bus.req = 3'b010;
        bus.req_pattern = 24'h00_08_00;
        sbq.push_back('{g: 3'b010, pat: 8'h08});
        wait_ack(ok);
        e = sbq.pop_front();
        if (ok) begin
            chk("r_grant", bus.grant, e.g);
            repeat (13) @(negedge clk);
            chk("r_led_before", led, 1);
            bus.req = 3'b111;
            rst = 1'b1;
            #1;
            chk("r_led", led, 0);
            chk("r_grant0", bus.grant, 0);
            chk("r_busy", bus.busy, 0);
            flag = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (bus.done !== 1'b0) flag = 1'b0;
            end
            chk("r_no_done", {31'd0, flag}, 32'd1);
        end

        // Back-to-back round robin with all requests held.
        gexp[0] = 3'b001;
        gexp[1] = 3'b010;
        gexp[2] = 3'b100;
        gexp[3] = 3'b001;
        for (int g = 0; g < 4; g++) sbq.push_back('{g: gexp[g], pat: 8'h00});
        bus.req = 3'b111;
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            gap = 0;
            while (bus.grant === 3'b000 && gap < 40) begin
                gap++;
                @(negedge clk);
            end
            if (g > 0) chk("rr_gap", gap, 1);
            e = sbq.pop_front();
            chk("rr_grant", bus.grant, e.g);
            cnt = 1;
            while (cnt < 40) begin
                @(negedge clk);
                if (bus.grant !== e.g) break;
                cnt++;
            end
            chk("rr_len", cnt, 32);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
